branch_redirect_ctrl: RTL and testbench

Sequences front-end recovery after the execute-stage branch unit resolves a conditional branch or JALR.
- Compares the resolved decision and target against the fetch-time prediction.
- On a mispredict: raises a one-cycle flush and holds a redirect PC toward fetch under a valid/ready handshake.
- Then discards wrong-path resolutions for a programmable drain window.
- Sits between the exe stage and the fetch/PC-generation logic.

---
 rtl/branch_redirect_ctrl.sv | 131 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: detects exe-stage mispredicts, pulses flush, hands a redirect PC to fetch, then drains.
// Optional performance counters are built when BRANCH_REDIRECT_PERF_EN is defined; otherwise the counter ports read 0.
`timescale 1ns/1ps
module branch_redirect_ctrl #(
   parameter int PC_W         = 64,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             valid_i,
   input  logic             is_branch_i,
   input  logic             taken_i,
   input  logic [PC_W-1:0]  target_i,
   input  logic             pred_taken_i,
   input  logic [PC_W-1:0]  pred_target_i,
   input  logic             kill_i,
   output logic             redirect_valid_o,
   output logic [PC_W-1:0]  redirect_pc_o,
   input  logic             redirect_ready_i,
   output logic             flush_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   // Redirect handshake: a transfer happens on a rising edge where redirect_valid_o and
   // redirect_ready_i are both 1; redirect_pc_o stays constant until then.
   typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   state_e          state_q, state_d;
   logic            rvalid_q, rvalid_d;
   logic [PC_W-1:0] rpc_q, rpc_d;
   logic            flush_q, flush_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic            mispred;

   // A not-taken branch falls through, so only a taken branch has a target to verify.
   assign mispred = valid_i & is_branch_i &
                    ((taken_i != pred_taken_i) | (taken_i & (target_i != pred_target_i)));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         rvalid_q <= 1'b0;
         rpc_q    <= '0;
         flush_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         rpc_q    <= rpc_d;
         flush_q  <= flush_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rvalid_d = rvalid_q;
      rpc_d    = rpc_q;
      flush_d  = 1'b0;
      cnt_d    = cnt_q;
      if (kill_i) begin
         state_d  = IDLE;
         rvalid_d = 1'b0;
         cnt_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mispred) begin
                  state_d  = REDIRECT;
                  rvalid_d = 1'b1;
                  rpc_d    = target_i;
                  flush_d  = 1'b1;
               end
            end
            REDIRECT: begin
               if (redirect_ready_i) begin
                  rvalid_d = 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DRAIN;
                     cnt_d   = DRAIN_INIT;
                  end
               end
            end
            DRAIN: begin
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
            end
         endcase
      end
   end

   assign redirect_valid_o = rvalid_q;
   assign redirect_pc_o    = rpc_q;
   assign flush_o          = flush_q;
   assign busy_o           = (state_q != IDLE);

`ifdef BRANCH_REDIRECT_PERF_EN
   logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if ((state_q == IDLE) && valid_i && is_branch_i && !kill_i)
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
         if ((state_q == IDLE) && (state_d == REDIRECT))
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`else
   assign branch_cnt_o  = '0;
   assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl (PC_W=64, DRAIN_CYCLES=2, CNT_W=4); counter expectations
// follow BRANCH_REDIRECT_PERF_EN and read 0 when it is undefined.
`timescale 1ns/1ps
module tb_branch_redirect_ctrl;

   localparam int PC_W  = 64;
   localparam int CNT_W = 4;
`ifdef BRANCH_REDIRECT_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             valid = 1'b0, is_branch = 1'b0, taken = 1'b0, pred_taken = 1'b0;
   logic [PC_W-1:0]  target = '0, pred_target = '0;
   logic             kill = 1'b0, ready = 1'b0;
   logic             rvalid, flush, busy;
   logic [PC_W-1:0]  rpc;
   logic [CNT_W-1:0] br_cnt, mp_cnt;

   int checks_total  = 0;
   int checks_passed = 0;
   int exp_br = 0;
   int exp_mp = 0;

   branch_redirect_ctrl #(.PC_W(PC_W), .DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rstn_i(rstn), .valid_i(valid), .is_branch_i(is_branch),
      .taken_i(taken), .target_i(target), .pred_taken_i(pred_taken),
      .pred_target_i(pred_target), .kill_i(kill), .redirect_valid_o(rvalid),
      .redirect_pc_o(rpc), .redirect_ready_i(ready), .flush_o(flush), .busy_o(busy),
      .branch_cnt_o(br_cnt), .mispred_cnt_o(mp_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic tk, input logic ptk,
                        input logic [PC_W-1:0] tg, input logic [PC_W-1:0] ptg);
      valid = v; is_branch = v; taken = tk; pred_taken = ptk;
      target = tg; pred_target = ptg;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "_brcnt"}, 64'(br_cnt), PERF ? 64'(exp_br % 16) : 64'd0);
      check({tag, "_mpcnt"}, 64'(mp_cnt), PERF ? 64'(exp_mp % 16) : 64'd0);
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic ef, input logic eb);
      check({tag, "_rvalid"}, 64'(rvalid), 64'(ev));
      check({tag, "_flush"},  64'(flush),  64'(ef));
      check({tag, "_busy"},   64'(busy),   64'(eb));
   endtask

   initial begin
      // reset
      #3;
      check_outs("rst", 1'b0, 1'b0, 1'b0);
      check("rst_pc", rpc, 64'd0);
      check_cnts("rst");
      @(negedge clk); @(negedge clk);
      rstn = 1'b1;
      tick();

      // 1: correct prediction
      drive(1'b1, 1'b1, 1'b1, 64'h8000_0040, 64'h8000_0040);
      tick(); exp_br++;
      idle_in();
      check_outs("t1", 1'b0, 1'b0, 1'b0);
      check_cnts("t1");

      // 2: direction mispredict, fetch ready at once, then mispredict on first IDLE cycle
      drive(1'b1, 1'b0, 1'b1, 64'h1004, 64'h2000);
      tick(); exp_br++; exp_mp++;
      idle_in(); ready = 1'b1;
      check_outs("t2_n1", 1'b1, 1'b1, 1'b1);
      check("t2_n1_pc", rpc, 64'h1004);
      check_cnts("t2_n1");
      tick();
      ready = 1'b0;
      check_outs("t2_n2", 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 64'h7770, 64'h0);  // wrong path, ignored in DRAIN
      tick();
      idle_in();
      check_outs("t2_n3", 1'b0, 1'b0, 1'b1);
      tick();
      check_outs("t2_n4", 1'b0, 1'b0, 1'b0);
      check_cnts("t2_n4");
      drive(1'b1, 1'b1, 1'b0, 64'h5000, 64'h5000);
      tick(); exp_br++; exp_mp++;
      idle_in(); ready = 1'b1;
      check_outs("t2_b2b", 1'b1, 1'b1, 1'b1);
      check("t2_b2b_pc", rpc, 64'h5000);
      tick(); ready = 1'b0;
      tick(); tick();
      check_outs("t2_b2b_end", 1'b0, 1'b0, 1'b0);

      // 3: target mispredict with 5 cycles of backpressure
      drive(1'b1, 1'b1, 1'b1, 64'h2000, 64'h2100);
      tick(); exp_br++; exp_mp++;
      idle_in();
      check_outs("t3_c1", 1'b1, 1'b1, 1'b1);
      check("t3_c1_pc", rpc, 64'h2000);
      for (int i = 2; i <= 5; i++) begin
         if (i == 3) drive(1'b1, 1'b0, 1'b1, 64'h3000, 64'h3000);
         tick();
         idle_in();
         check_outs($sformatf("t3_c%0d", i), 1'b1, 1'b0, 1'b1);
         check($sformatf("t3_c%0d_pc", i), rpc, 64'h2000);
      end
      check_cnts("t3_hold");
      ready = 1'b1;
      tick(); ready = 1'b0;
      check_outs("t3_acc", 1'b0, 1'b0, 1'b1);
      tick(); tick();
      check_outs("t3_end", 1'b0, 1'b0, 1'b0);

      // 4: kill on second REDIRECT cycle
      drive(1'b1, 1'b0, 1'b1, 64'h4000, 64'h0);
      tick(); exp_br++; exp_mp++;
      idle_in();
      tick();
      check_outs("t4_c2", 1'b1, 1'b0, 1'b1);
      kill = 1'b1;
      tick(); kill = 1'b0;
      check_outs("t4_kill", 1'b0, 1'b0, 1'b0);
      tick();
      check_outs("t4_after", 1'b0, 1'b0, 1'b0);

      // 5: kill beats a same-cycle mispredict in IDLE
      drive(1'b1, 1'b1, 1'b0, 64'h6000, 64'h6000);
      kill = 1'b1;
      tick();
      kill = 1'b0; idle_in();
      check_outs("t5", 1'b0, 1'b0, 1'b0);
      check_cnts("t5");

      // reset asserted mid-REDIRECT drops everything immediately
      drive(1'b1, 1'b0, 1'b1, 64'h9000, 64'h0);
      tick();
      idle_in();
      check_outs("rst2_pre", 1'b1, 1'b1, 1'b1);
      #2 rstn = 1'b0;
      #1;
      exp_br = 0; exp_mp = 0;
      check_outs("rst2", 1'b0, 1'b0, 1'b0);
      check("rst2_pc", rpc, 64'd0);
      check_cnts("rst2");
      @(negedge clk);
      rstn = 1'b1;

      // 6: 17 correct predictions wrap a 4-bit counter to 1
      drive(1'b1, 1'b0, 1'b0, 64'h104, 64'h0);
      for (int i = 0; i < 17; i++) begin
         tick(); exp_br++;
      end
      idle_in();
      check_outs("t6", 1'b0, 1'b0, 1'b0);
      check_cnts("t6");
      check("t6_wrap", 64'(br_cnt), PERF ? 64'd1 : 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
